cfg_msg_router: RTL and testbench
=================================

CFG_MSG_ROUTER -- requirements
Module: cfg_msg_router

Interface
- REQ-001: Parameter ADDR_SIZE, default 4, width of the message address field.
- REQ-002: Parameter PAYLOAD_SIZE, default 8, width of the message payload field.
- REQ-003: Parameter NUM_OUT, default 4, number of downstream configuration-register ports (2..16).
- REQ-004: Parameter BASE_ADDR, default 4'b0000, address routed to output port 0.
- REQ-005: Port clk, input, 1, single clock; all state updates on its rising edge.
- REQ-006: Port reset, input, 1, asynchronous active-low reset (asserted when 0).
- REQ-007: Port recv_val, input, 1, upstream message valid.
- REQ-008: Port recv_rdy, output, 1, block can accept a message this cycle.
- REQ-009: Port recv_msg, input, ADDR_SIZE+PAYLOAD_SIZE+1, message {addr, write, payload}: addr = [MSB:PAYLOAD_SIZE+1], write = [PAYLOAD_SIZE], payload = [PAYLOAD_SIZE-1:0].
- REQ-010: Port send_val, output, NUM_OUT, per-port valid, at most one bit set.
- REQ-011: Port send_rdy, input, NUM_OUT, per-port ready from downstream config registers.
- REQ-012: Port send_msg, output, ADDR_SIZE+PAYLOAD_SIZE+1, message bus shared by all ports.
- REQ-013: Port drop_count, output, 8, count of messages discarded for out-of-range address.

Function
- REQ-014: The block SHALL hold a 2-entry FIFO (count 0..2, head/tail pointers wrapping modulo 2).
- REQ-015: A transfer in SHALL occur on any cycle with recv_val && recv_rdy; the message is written unmodified, including the write bit.
- REQ-016: recv_rdy SHALL equal (count < 2), derived from registered state only; a full FIFO SHALL NOT accept in the same cycle it dequeues (no full-bypass).
- REQ-017: No empty-bypass: a message accepted in cycle N SHALL first appear on send_msg/send_val in cycle N+1.
- REQ-018: Head index idx = head.addr - BASE_ADDR, computed in ADDR_SIZE-bit unsigned arithmetic with wrap; the head is routable iff idx < NUM_OUT.
- REQ-019: When count > 0 and the head is routable, send_val[idx] SHALL be 1, all other bits 0, and send_msg SHALL equal the head entry.
- REQ-020: When count == 0, send_val SHALL be all 0 and send_msg SHALL be 0.
- REQ-021: A routable head SHALL dequeue on the cycle send_val[idx] && send_rdy[idx]; send_rdy bits of other ports SHALL be ignored.
- REQ-022: A non-routable head SHALL assert no send_val bit, SHALL dequeue unconditionally on the first cycle it is at the head, and SHALL increment drop_count.
- REQ-023: drop_count SHALL saturate at 255.
- REQ-024: A simultaneous enqueue and dequeue with count == 1 SHALL leave count at 1 and present the new entry as head on the next cycle.
- REQ-025: Order SHALL be preserved: messages leave (or drop) in acceptance order; a stalled head SHALL block all later messages (head-of-line blocking).
- REQ-026: send_val[idx] SHALL remain asserted and send_msg stable until the handshake completes.

Reset
- REQ-027: While reset == 0, count, pointers and drop_count SHALL be 0 immediately, regardless of clk; recv_rdy = 1, send_val = 0, send_msg = 0.
- REQ-028: Reset asserted mid-transfer SHALL discard all buffered messages without any send handshake; FIFO contents need not be cleared.
- REQ-029: After reset deasserts, the first message SHALL be accepted on the first rising edge with recv_val = 1.

Verification
- REQ-030: Send addr=2, write=1, payload=0xA5 with all send_rdy = 1 -> cycle+1 send_val = 4'b0100, send_msg = {4'h2, 1, 8'hA5}, dequeued that edge, drop_count = 0.
- REQ-031: Hold send_rdy = 0, push 3 messages back-to-back -> first two accepted, recv_rdy = 0 on the third, send_val held; release send_rdy -> both delivered in order, third then accepted.
- REQ-032: Send addr=9 (NUM_OUT = 4, BASE_ADDR = 0) -> no send_val asserted, drop_count = 1 one cycle after it reaches the head; 300 such messages -> drop_count = 255.
- REQ-033: Head for port 1 with send_rdy = 4'b1101 -> head stalls, send_val = 4'b0010 held, no dequeue until send_rdy[1] = 1.
- REQ-034: Assert reset asynchronously between edges with count = 2 -> recv_rdy = 1, send_val = 0, drop_count = 0 before the next edge; neither message is later delivered.
- REQ-035: With count = 1, enqueue and dequeue in the same cycle -> count stays 1, new message on send_msg the next cycle, no loss or duplication.

Source files
------------

// File: rtl/cfg_msg_router_if.sv
// Handshake bundle between the config-message router, its upstream source and
// the per-port downstream config registers.
interface cfg_msg_router_if #(
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8,
    parameter int NUM_OUT      = 4
);
    localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;

    logic               recv_val;
    logic               recv_rdy;
    logic [MSG_W-1:0]   recv_msg;
    logic [NUM_OUT-1:0] send_val;
    logic [NUM_OUT-1:0] send_rdy;
    logic [MSG_W-1:0]   send_msg;

    // Environment side: drives the upstream message and the downstream readies.
    modport master (
        output recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, send_msg
    );

    // Router side.
    modport slave (
        input  recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, send_msg
    );
endinterface

// File: rtl/cfg_msg_router.sv
// Routes {addr, write, payload} messages through a 2-entry FIFO to one of
// NUM_OUT config-register ports; out-of-range addresses are dropped and counted.
module cfg_msg_router #(
    parameter int                    ADDR_SIZE    = 4,
    parameter int                    PAYLOAD_SIZE = 8,
    parameter int                    NUM_OUT      = 4,
    parameter logic [ADDR_SIZE-1:0]  BASE_ADDR    = '0
) (
    input  logic             clk,
    input  logic             reset,
    cfg_msg_router_if.slave  bus,
    output logic [7:0]       drop_count
);
    localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;

    logic [MSG_W-1:0]     mem_q [2];
    logic                 head_q, tail_q;
    logic [1:0]           count_q, count_d;
    logic [7:0]           drop_q;

    logic [MSG_W-1:0]     head_msg;
    logic [ADDR_SIZE-1:0] head_idx;
    logic [NUM_OUT-1:0]   sel;
    logic                 non_empty, routable, enq, deq, drop;

    // Head decode: idx wraps in ADDR_SIZE bits, so addresses below BASE_ADDR
    // land high and fall out of range rather than aliasing onto low ports.
    always_comb begin
        head_msg  = mem_q[head_q];
        head_idx  = head_msg[MSG_W-1 -: ADDR_SIZE] - BASE_ADDR;
        non_empty = (count_q != 2'd0);
        routable  = (32'(head_idx) < NUM_OUT);
        sel       = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            sel[i] = (32'(head_idx) == i);
        end
    end

    assign bus.recv_rdy = (count_q != 2'd2);
    assign bus.send_val = (non_empty && routable) ? sel : '0;
    assign bus.send_msg = non_empty ? head_msg : '0;
    assign drop_count   = drop_q;

    assign enq  = bus.recv_val && bus.recv_rdy;
    assign drop = non_empty && !routable;
    assign deq  = drop || (|(bus.send_val & bus.send_rdy));

    always_comb begin
        count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end

    // NOTE: FIFO storage has no reset; the pointers and count define validity,
    // so stale entries are never observable and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= bus.recv_msg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            drop_q  <= 8'd0;
        end else begin
            count_q <= count_d;
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_cfg_msg_router.sv
// Directed bench for cfg_msg_router: stimulus pushes expected deliveries into a
// scoreboard queue and a negedge monitor pops and compares on every handshake.
module tb_cfg_msg_router;
    localparam int AW = 4;
    localparam int PW = 8;
    localparam int NO = 4;
    localparam int MW = AW + PW + 1;

    typedef struct {
        int            port;
        logic [MW-1:0] msg;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] drop_count;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    cfg_msg_router_if #(.ADDR_SIZE(AW), .PAYLOAD_SIZE(PW), .NUM_OUT(NO)) bus ();

    cfg_msg_router #(
        .ADDR_SIZE(AW), .PAYLOAD_SIZE(PW), .NUM_OUT(NO), .BASE_ADDR(4'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [3:0] a, input logic w, input logic [7:0] p);
        return {a, w, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one message for a single cycle; it must be accepted on this edge.
    task automatic push_msg(input logic [MW-1:0] m);
        logic [3:0] a;
        exp_t       e;
        a = m[MW-1 -: AW];
        check("recv_rdy_accept", 32'(bus.recv_rdy), 32'd1);
        if (int'(a) < NO) begin
            e.port = int'(a);
            e.msg  = m;
            sb_q.push_back(e);
        end
        bus.recv_val = 1'b1;
        bus.recv_msg = m;
        tick();
        bus.recv_val = 1'b0;
    endtask

    // Monitor: every completed send handshake must match the oldest expectation.
    always @(negedge clk) begin : monitor
        int   port;
        exp_t e;
        if (reset && (bus.send_val != '0)) begin
            check("send_val_onehot", 32'($countones(bus.send_val)), 32'd1);
        end
        if (reset && (|(bus.send_val & bus.send_rdy))) begin
            port = -1;
            for (int i = 0; i < NO; i++) begin
                if (bus.send_val[i]) port = i;
            end
            if (sb_q.size() == 0) begin
                check("unexpected_send", 32'(bus.send_msg), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("deliver_port", 32'(port), 32'(e.port));
                check("deliver_msg", 32'(bus.send_msg), 32'(e.msg));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [MW-1:0] m;
        bus.recv_val = 1'b0;
        bus.recv_msg = '0;
        bus.send_rdy = '0;
        reset        = 1'b0;

        // Reset state, sampled before any clock edge
        #2;
        check("rst_recv_rdy", 32'(bus.recv_rdy), 32'd1);
        check("rst_send_val", 32'(bus.send_val), 32'd0);
        check("rst_send_msg", 32'(bus.send_msg), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        #10 reset = 1'b1;
        tick();

        // Single routable message, all ports ready
        bus.send_rdy = 4'hF;
        push_msg(mk(4'h2, 1'b1, 8'hA5));
        check("single_send_val", 32'(bus.send_val), 32'h4);
        check("single_send_msg", 32'(bus.send_msg), 32'(mk(4'h2, 1'b1, 8'hA5)));
        tick();
        check("single_dequeued", 32'(bus.send_val), 32'h0);
        check("single_drop_count", 32'(drop_count), 32'd0);

        // Fill while stalled; third waits until space frees
        bus.send_rdy = 4'h0;
        push_msg(mk(4'h1, 1'b0, 8'h11));
        push_msg(mk(4'h3, 1'b1, 8'h22));
        check("full_recv_rdy", 32'(bus.recv_rdy), 32'd0);
        bus.recv_val = 1'b1;
        bus.recv_msg = mk(4'h0, 1'b1, 8'h33);
        tick();
        check("full_hold_rdy", 32'(bus.recv_rdy), 32'd0);
        check("full_hold_val", 32'(bus.send_val), 32'h2);
        check("full_hold_msg", 32'(bus.send_msg), 32'(mk(4'h1, 1'b0, 8'h11)));
        bus.send_rdy = 4'hF;
        tick();
        check("drain_recv_rdy", 32'(bus.recv_rdy), 32'd1);
        check("drain_second_msg", 32'(bus.send_msg), 32'(mk(4'h3, 1'b1, 8'h22)));
        sb_q.push_back('{1, mk(4'h1, 1'b0, 8'h11)});
        sb_q.delete(sb_q.size() - 1);
        begin
            exp_t e;
            e.port = 0;
            e.msg  = mk(4'h0, 1'b1, 8'h33);
            sb_q.push_back(e);
        end
        tick();
        bus.recv_val = 1'b0;
        check("drain_third_val", 32'(bus.send_val), 32'h1);
        check("drain_third_msg", 32'(bus.send_msg), 32'(mk(4'h0, 1'b1, 8'h33)));
        tick();
        check("drain_empty", 32'(bus.send_val), 32'h0);

        // Head-of-line stall: other ports ready must not release port 1
        bus.send_rdy = 4'b1101;
        push_msg(mk(4'h1, 1'b1, 8'h44));
        for (int i = 0; i < 3; i++) begin
            check("stall_send_val", 32'(bus.send_val), 32'h2);
            check("stall_send_msg", 32'(bus.send_msg), 32'(mk(4'h1, 1'b1, 8'h44)));
            tick();
        end
        bus.send_rdy = 4'b0010;
        tick();
        check("stall_released", 32'(bus.send_val), 32'h0);

        // Simultaneous enqueue and dequeue at count 1
        bus.send_rdy = 4'h0;
        push_msg(mk(4'h0, 1'b0, 8'h55));
        bus.send_rdy = 4'hF;
        push_msg(mk(4'h3, 1'b0, 8'h66));
        check("swap_send_msg", 32'(bus.send_msg), 32'(mk(4'h3, 1'b0, 8'h66)));
        check("swap_send_val", 32'(bus.send_val), 32'h8);
        check("swap_recv_rdy", 32'(bus.recv_rdy), 32'd1);
        tick();
        check("swap_empty", 32'(bus.send_val), 32'h0);

        // Out-of-range drops, boundary idx == NUM_OUT, saturation at 255
        push_msg(mk(4'h9, 1'b1, 8'h77));
        check("drop_no_val", 32'(bus.send_val), 32'h0);
        check("drop_not_yet", 32'(drop_count), 32'd0);
        push_msg(mk(4'h4, 1'b0, 8'h78));
        check("drop_first", 32'(drop_count), 32'd1);
        check("drop_boundary_no_val", 32'(bus.send_val), 32'h0);
        for (int i = 0; i < 298; i++) begin
            bus.recv_val = 1'b1;
            bus.recv_msg = mk(4'h9, i[0], i[7:0]);
            tick();
        end
        bus.recv_val = 1'b0;
        push_msg(mk(4'h0, 1'b1, 8'h88));
        check("drop_saturated", 32'(drop_count), 32'd255);
        check("after_drop_val", 32'(bus.send_val), 32'h1);
        tick();
        check("drop_still_sat", 32'(drop_count), 32'd255);

        // Asynchronous reset with two buffered messages
        bus.send_rdy = 4'h0;
        bus.recv_val = 1'b1;
        bus.recv_msg = mk(4'h2, 1'b1, 8'hF1);
        tick();
        bus.recv_msg = mk(4'h1, 1'b0, 8'hF2);
        tick();
        bus.recv_val = 1'b0;
        check("pre_rst_full", 32'(bus.recv_rdy), 32'd0);
        check("pre_rst_val", 32'(bus.send_val), 32'h4);
        #2 reset = 1'b0;
        #1;
        check("async_rst_recv_rdy", 32'(bus.recv_rdy), 32'd1);
        check("async_rst_send_val", 32'(bus.send_val), 32'h0);
        check("async_rst_send_msg", 32'(bus.send_msg), 32'h0);
        check("async_rst_drop", 32'(drop_count), 32'd0);
        #3;
        bus.send_rdy = 4'hF;
        reset = 1'b1;
        tick();
        tick();
        check("post_rst_no_val", 32'(bus.send_val), 32'h0);
        check("post_rst_rdy", 32'(bus.recv_rdy), 32'd1);
        push_msg(mk(4'h3, 1'b1, 8'h99));
        check("post_rst_send_val", 32'(bus.send_val), 32'h8);
        tick();
        check("post_rst_empty", 32'(bus.send_val), 32'h0);

        tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
